// File: rtl/dct_pkg.sv
// Shared types and constants for the 8x8 DCT block sequencer.
//   dct_seq_state_t : sequencer state (LOAD, COMPUTE, EMIT)
//   DCT_N / DCT_BLK : block edge length and pixel count
//   DCT_FRAC_BITS   : fractional bits of the cosine LUT term
//   DCT_ACC_W       : MAC operand / accumulator width
//   dct_idx_t       : 3-bit row/column/frequency index
package dct_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } dct_seq_state_t;

  localparam int DCT_N         = 8;
  localparam int DCT_BLK       = 64;
  localparam int DCT_FRAC_BITS = 8;
  localparam int DCT_ACC_W     = 32;

  typedef logic [2:0] dct_idx_t;

endpackage

// File: rtl/dct_block_sequencer_if.sv
// Bus bundle between the DCT sequencer, its pixel source, the external
// cosine LUT bank and the coefficient sink.
//   pix_*  : pixel stream in (valid/ready)
//   lut_*  : frequency/spatial select out, cos_term (signed Q8) back in
//   coef_* : coefficient stream out (valid/ready), with frequency tag and last
// modport master = sequencer side, modport slave = environment side.
interface dct_block_sequencer_if
  import dct_pkg::*;
#(
  parameter int COEF_W = 16
) ();

  logic                          pix_valid;
  logic [7:0]                    pix_data;
  logic                          pix_ready;

  dct_idx_t                      lut_k1;
  dct_idx_t                      lut_k2;
  dct_idx_t                      lut_n1;
  dct_idx_t                      lut_n2;
  logic signed [DCT_ACC_W-1:0]   cos_term;

  logic                          coef_valid;
  logic signed [COEF_W-1:0]      coef_data;
  dct_idx_t                      coef_k1;
  dct_idx_t                      coef_k2;
  logic                          coef_last;
  logic                          coef_ready;

  modport master (
    input  pix_valid, pix_data, cos_term, coef_ready,
    output pix_ready, lut_k1, lut_k2, lut_n1, lut_n2,
           coef_valid, coef_data, coef_k1, coef_k2, coef_last
  );

  modport slave (
    output pix_valid, pix_data, cos_term, coef_ready,
    input  pix_ready, lut_k1, lut_k2, lut_n1, lut_n2,
           coef_valid, coef_data, coef_k1, coef_k2, coef_last
  );

endinterface

// File: rtl/dct_mac.sv
// Registered signed multiply-accumulate.
//   clk, rst_n : clock, async active-low reset (acc -> 0)
//   clr        : synchronous clear of acc (wins over en)
//   en         : acc <= acc + a*b
//   a, b       : signed operands
//   acc        : registered accumulator
//   sum        : acc + a*b, combinational, so the caller can capture the
//                final total in the same cycle as the last product
module dct_mac
  import dct_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [DCT_ACC_W-1:0] a,
  input  logic signed [DCT_ACC_W-1:0] b,
  output logic signed [DCT_ACC_W-1:0] acc,
  output logic signed [DCT_ACC_W-1:0] sum
);

  assign sum = acc + a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/dct_block_sequencer.sv
// 8x8 2-D DCT sequencer over an external per-(k1,k2) cosine LUT bank.
// Buffers 64 pixels, then for each frequency k (raster, k1-major) walks all
// 64 positions n, accumulating pixel * cos_term, and streams the floor-shifted
// coefficient out with valid/ready.
//   clk, rst_n : clock, async active-low reset
//   bus        : dct_block_sequencer_if.master (pixel in, LUT select, coef out)
//   busy       : high in COMPUTE or EMIT
// Build option: DCT_LEVEL_SHIFT_EN -- store pixels as pix_data - 128 (signed)
// instead of zero-extended unsigned.
//
// state   | meaning
// --------+---------------------------------------------------------------
// LOAD    | pix_ready=1, each pix_valid writes pix_buf[pcnt]; 64th -> COMPUTE
// COMPUTE | one MAC per cycle for position n of frequency k; n=63 -> EMIT
// EMIT    | coefficient held valid until coef_ready; then next k or LOAD
module dct_block_sequencer
  import dct_pkg::*;
#(
  parameter int FRAC_BITS = DCT_FRAC_BITS,
  parameter int COEF_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dct_block_sequencer_if.master bus,
  output logic                  busy
);

  localparam logic [5:0] LAST_IDX = 6'(DCT_BLK - 1);

  dct_seq_state_t state;
  logic [5:0]     pcnt;
  logic [5:0]     k;
  logic [5:0]     n;

  logic                     pix_ready_r;
  logic                     coef_valid_r;
  logic signed [COEF_W-1:0] coef_data_r;
  dct_idx_t                 coef_k1_r;
  dct_idx_t                 coef_k2_r;
  logic                     coef_last_r;

  logic signed [8:0] pix_in;
  logic signed [8:0] pix_buf [DCT_BLK];
  logic signed [DCT_ACC_W-1:0] mac_a;
  logic signed [DCT_ACC_W-1:0] mac_acc;
  logic signed [DCT_ACC_W-1:0] mac_sum;

`ifdef DCT_LEVEL_SHIFT_EN
  assign pix_in = $signed({1'b0, bus.pix_data}) - 9'sd128;
`else
  assign pix_in = $signed({1'b0, bus.pix_data});
`endif

  // Pixel storage needs no reset: every entry is rewritten before COMPUTE.
  always_ff @(posedge clk) begin
    if (state == LOAD && bus.pix_valid) begin
      pix_buf[pcnt] <= pix_in;
    end
  end

  assign mac_a = {{(DCT_ACC_W-9){pix_buf[n][8]}}, pix_buf[n]};

  // Accumulator is held at zero in every non-COMPUTE cycle, so each
  // frequency starts from a clean sum without an explicit clear strobe.
  dct_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != COMPUTE),
    .en    (state == COMPUTE),
    .a     (mac_a),
    .b     (bus.cos_term),
    .acc   (mac_acc),
    .sum   (mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      pcnt         <= '0;
      k            <= '0;
      n            <= '0;
      pix_ready_r  <= 1'b1;
      busy         <= 1'b0;
      coef_valid_r <= 1'b0;
      coef_data_r  <= '0;
      coef_k1_r    <= '0;
      coef_k2_r    <= '0;
      coef_last_r  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.pix_valid) begin
            pcnt <= pcnt + 6'd1;
            if (pcnt == LAST_IDX) begin
              state       <= COMPUTE;
              k           <= '0;
              n           <= '0;
              pix_ready_r <= 1'b0;
              busy        <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (n == LAST_IDX) begin
            // n stays at 63 so the LUT selects hold through EMIT.
            state        <= EMIT;
            coef_valid_r <= 1'b1;
            coef_data_r  <= COEF_W'(mac_sum >>> FRAC_BITS);
            coef_k1_r    <= k[5:3];
            coef_k2_r    <= k[2:0];
            coef_last_r  <= (k == LAST_IDX);
          end else begin
            n <= n + 6'd1;
          end
        end
        EMIT: begin
          if (bus.coef_ready) begin
            coef_valid_r <= 1'b0;
            if (k == LAST_IDX) begin
              state       <= LOAD;
              pcnt        <= '0;
              pix_ready_r <= 1'b1;
              busy        <= 1'b0;
            end else begin
              state <= COMPUTE;
              k     <= k + 6'd1;
              n     <= '0;
            end
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  assign bus.pix_ready  = pix_ready_r;
  assign bus.lut_k1     = k[5:3];
  assign bus.lut_k2     = k[2:0];
  assign bus.lut_n1     = n[5:3];
  assign bus.lut_n2     = n[2:0];
  assign bus.coef_valid = coef_valid_r;
  assign bus.coef_data  = coef_data_r;
  assign bus.coef_k1    = coef_k1_r;
  assign bus.coef_k2    = coef_k2_r;
  assign bus.coef_last  = coef_last_r;

endmodule

// File: doc/dct_block_sequencer.md
# dct_block_sequencer

Sequences one 8x8 two-dimensional DCT at a time over the shared per-(k1,k2) cosine LUT bank. It buffers 64 input pixels, then for each of the 64 output frequencies walks all 64 spatial positions. For each position it drives the LUT select lines, multiplies the pixel by the returned Q8 cosine term and accumulates. Each finished coefficient is streamed out with a valid/ready handshake. It sits between the pixel block reader and the quantiser in the DCT pipeline.

## Interface
- `FRAC_BITS`, 8: fractional bits of `cos_term`; the accumulator is arithmetically shifted right by this amount.
- `COEF_W`, 16: width of the signed output coefficient.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pix_valid` in 1: input pixel valid.
- `pix_data` in 8: unsigned pixel in raster order. Index i maps to n1=i[5:3], n2=i[2:0].
- `pix_ready` out 1: high while in LOAD.
- `lut_k1`, `lut_k2` out 3 each: frequency select to the LUT bank.
- `lut_n1`, `lut_n2` out 3 each: spatial select to the LUT bank.
- `cos_term` in 32: signed Q8 term returned combinationally in the same cycle.
- `coef_valid` out 1: coefficient available.
- `coef_data` out COEF_W: signed coefficient.
- `coef_k1`, `coef_k2` out 3 each: frequency of `coef_data`.
- `coef_last` out 1: high with the (7,7) coefficient.
- `coef_ready` in 1: downstream accepts.
- `busy` out 1: high in COMPUTE or EMIT.

## Operation
- States: LOAD, COMPUTE, EMIT.
- **LOAD**
  - `pix_ready`=1.
  - Each `pix_valid` cycle writes `pix_data` to `buf[pcnt]` and increments the 6-bit `pcnt`.
  - The write with `pcnt`=63 moves to COMPUTE with k=0, n=0, acc=0.
- **COMPUTE**
  - `lut_k1`/`lut_k2` = k[5:3]/k[2:0]; `lut_n1`/`lut_n2` = n[5:3]/n[2:0].
  - Each cycle: acc += sext(buf[n]) * `cos_term`. Operands are 32-bit signed; acc is 32-bit signed and cannot overflow, since |sum| ≤ 64·255·256.
  - At n=63 the state moves to EMIT. `coef_data` is registered as (acc_final >>> FRAC_BITS), i.e. floor, truncated to COEF_W.
- **EMIT**
  - `coef_valid`=1; `coef_data`, `coef_k1`, `coef_k2`, `coef_last` are held stable until `coef_ready`.
  - On handshake with k<63: k++, n=0, acc=0, go to COMPUTE.
  - On handshake with k=63: `pcnt`=0, go to LOAD.
- Frequency order is raster, k1-major.
- Outside COMPUTE, the LUT select outputs hold their last value. Downstream must not rely on them.
- `pix_valid` outside LOAD is ignored.

## Timing
- Reset values: state=LOAD, `pix_ready`=1, `coef_valid`=0, `coef_data`=0, `coef_k1`=`coef_k2`=0, `coef_last`=0, `busy`=0, all LUT selects 0, counters and acc 0.
- `pix_ready` is high from the first cycle after reset deassertion.
- The last pixel accepted in cycle t puts the block in COMPUTE at t+1. The 64 MAC cycles span t+1 to t+64, and `coef_valid` rises at t+65.
- Per coefficient: 64 compute cycles plus 1 EMIT cycle, plus any stall cycles. With `coef_ready` held high a block takes 64·65 = 4160 cycles after load.
- The `coef_ready` handshake in cycle e gives COMPUTE (n=0) at e+1, with no bubble.
- Reset asserted mid-COMPUTE or mid-EMIT aborts the block. The next pixel loaded goes to `buf[0]`.
- Stalls in EMIT are unbounded. No pixels are accepted until the whole block has drained.

## Configuration
- `DCT_LEVEL_SHIFT_EN`
  - Defined: each pixel is stored as the signed value `pix_data` − 128 (9-bit) before the MAC.
  - Undefined: the pixel is zero-extended unsigned.
  - All other behaviour is identical.

## Structure
- Package `dct_pkg`:
  - the state enum `dct_seq_state_t` (LOAD, COMPUTE, EMIT);
  - constants `DCT_N`=8, `DCT_BLK`=64, `DCT_FRAC_BITS`=8, `DCT_ACC_W`=32;
  - typedef `dct_idx_t` (logic [2:0]).
- Sub-module `dct_mac`: registered multiply-accumulate with a synchronous clear and an enable, instantiated once.
- The cosine LUT bank stays external and is driven only through the `lut_*` ports.

## Test plan
- Macro undefined, bench models the LUT bank. All pixels 255, `coef_ready`=1:
  - (0,0) term 0x020 gives `coef_data`=2040 at k=(0,0);
  - all 63 AC coefficients = 0;
  - `coef_last` only on (7,7).
- Macro undefined, pixel (0,0)=255 and all others 0:
  - coef(1,7) = 255·0x030 >>> 8 = 47.
- Macro undefined, pixel (0,1)=255 and all others 0:
  - coef(1,7) = −35445 >>> 8 = −139.
- Macro defined, all pixels 128:
  - all 64 coefficients = 0, in raster k order.
- `coef_ready` low for 10 cycles at k=5:
  - `coef_data`/`coef_k*` stable throughout;
  - no pixel accepted;
  - COMPUTE resumes the cycle after the handshake.
- `rst_n` pulsed at MAC cycle 30 of k=12:
  - `coef_valid`=0 and `pix_ready`=1 immediately;
  - a fresh block then loads from index 0 and produces correct results.
